// File: rtl/tb_handshake_transmitter_if.sv
// tb_handshake_transmitter_if: 4-phase req/ack handshake carrying a 4-bit word
interface tb_handshake_transmitter_if;
  logic       req;
  logic       ack;
  logic [3:0] data;
  modport master(output req, data, input ack);
  modport slave(input req, data, output ack);
endinterface

// File: rtl/tb_handshake_transmitter.sv
// tb_handshake_transmitter: paced 4-phase req/ack sender of an incrementing 4-bit sequence
module tb_handshake_transmitter #(
  parameter int SYNC_STAGES    = 2,
  parameter int GAP_CYCLES     = 0,
  parameter int NUM_WORDS      = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  tb_handshake_transmitter_if.master        hs,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout,
  output logic [7:0]                        sent_count
);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, GAP, REQ_HI, REQ_LO, DONE, ERROR} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [GW-1:0]          gcnt;
  logic [TW-1:0]          tcnt;
  logic                   ack_s;
  logic [7:0]             next_count;
  assign ack_s      = sync[SYNC_STAGES-1];
  assign next_count = sent_count + 8'd1;
  assign busy       = state inside {GAP, REQ_HI, REQ_LO};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      hs.req     <= 1'b0;
      hs.data    <= 4'd1;
      done       <= 1'b0;
      timeout    <= 1'b0;
      sent_count <= 8'd0;
      gcnt       <= '0;
      tcnt       <= '0;
      sync       <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], hs.ack};
      case (state)
        IDLE:
          if (en && !ack_s) begin
            hs.req <= 1'b1;
            tcnt   <= '0;
            state  <= REQ_HI;
          end
        GAP:
          if (gcnt == GW'(1)) begin
            hs.req <= en;
            tcnt   <= '0;
            state  <= en ? REQ_HI : IDLE;
          end else gcnt <= gcnt - 1'b1;
        REQ_HI:
          if (ack_s) begin
            hs.req <= 1'b0;
            tcnt   <= '0;
            state  <= REQ_LO;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            hs.req  <= 1'b0;
            timeout <= 1'b1;
            state   <= ERROR;
          end else tcnt <= tcnt + 1'b1;
        REQ_LO:
          if (!ack_s) begin
            hs.data    <= hs.data + 4'd1;
            sent_count <= next_count;
            tcnt       <= '0;
            if (NUM_WORDS != 0 && next_count == 8'(NUM_WORDS)) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (GAP_CYCLES > 0) begin
              gcnt  <= GW'(GAP_CYCLES);
              state <= GAP;
            end else begin
              hs.req <= en;
              state  <= en ? REQ_HI : IDLE;
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            state   <= ERROR;
          end else tcnt <= tcnt + 1'b1;
        default: ;
      endcase
    end
endmodule
